// File: rtl/sitcp_tx_merger.sv
// Round-robin framer merging NCH user byte streams onto the SiTCP TX byte interface.
// Frame layout: SYNC_BYTE, channel id, payload, 16-bit payload length (MSB first).
module sitcp_tx_merger #(
  parameter int         NCH       = 4,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             OPEN,
  input  logic [NCH-1:0]   CH_EN,
  input  logic [NCH-1:0]   CH_VALID,
  input  logic [NCH*8-1:0] CH_DATA,
  input  logic [NCH-1:0]   CH_LAST,
  output logic [NCH-1:0]   CH_READY,
  input  logic             TX_FULL,
  output logic             TX_WR,
  output logic [7:0]       TX_DATA,
  output logic             BUSY,
  output logic [3:0]       GRANT_ID,
  output logic [CNT_W-1:0] ABORT_CNT
);

  typedef enum logic [2:0] {
    S_IDLE, S_HSYNC, S_HID, S_PAY, S_TLH, S_TLL, S_FLUSH
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_grant, r_ptr;
  logic [15:0]      r_len, w_len_nxt;
  logic             r_tx_wr;
  logic [7:0]       r_tx_data;
  logic [CNT_W-1:0] r_abort;

  logic [NCH-1:0]   w_elig, w_grant_oh;
  logic [3:0]       w_sel_hi, w_sel_lo, w_sel, w_ptr_nxt;
  logic             w_found_hi, w_found_any;
  logic             w_g_valid, w_g_last;
  logic [7:0]       w_g_data;
  logic             w_emit, w_grant_load, w_abort_inc, w_ready_en;
  logic [7:0]       w_emit_byte;

  assign w_elig = CH_EN & CH_VALID;

  // Lowest eligible index at or above the pointer wins; otherwise wrap to the lowest overall.
  always_comb begin : p_select
    w_found_hi  = 1'b0;
    w_found_any = 1'b0;
    w_sel_hi    = 4'h0;
    w_sel_lo    = 4'h0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_found_any = 1'b1;
        w_sel_lo    = 4'(i);
        if (4'(i) >= r_ptr) begin
          w_found_hi = 1'b1;
          w_sel_hi   = 4'(i);
        end
      end
    end
    w_sel     = w_found_hi ? w_sel_hi : w_sel_lo;
    w_ptr_nxt = (w_sel == 4'(NCH - 1)) ? 4'h0 : w_sel + 4'h1;
  end

  always_comb begin : p_grant_mux
    w_grant_oh = '0;
    w_g_valid  = 1'b0;
    w_g_last   = 1'b0;
    w_g_data   = 8'h00;
    for (int i = 0; i < NCH; i++) begin
      if (r_grant == 4'(i)) begin
        w_grant_oh[i] = 1'b1;
        w_g_valid     = CH_VALID[i];
        w_g_last      = CH_LAST[i];
        w_g_data      = CH_DATA[8*i +: 8];
      end
    end
  end

  always_comb begin : p_fsm
    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    w_state_nxt  = r_state;
    w_emit       = 1'b0;
    w_emit_byte  = 8'h00;
    w_len_nxt    = r_len;
    w_grant_load = 1'b0;
    w_abort_inc  = 1'b0;
    w_ready_en   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (OPEN && w_found_any) begin
          w_grant_load = 1'b1;
          w_len_nxt    = 16'h0000;
          w_state_nxt  = S_HSYNC;
        end
      end
      S_HSYNC: begin
        if (!OPEN) begin
          w_abort_inc = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (!TX_FULL) begin
          w_emit      = 1'b1;
          w_emit_byte = SYNC_BYTE;
          w_state_nxt = S_HID;
        end
      end
      S_HID: begin
        if (!OPEN) begin
          w_abort_inc = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (!TX_FULL) begin
          w_emit      = 1'b1;
          w_emit_byte = {4'h0, r_grant};
          w_state_nxt = S_PAY;
        end
      end
      S_PAY: begin
        if (!OPEN) begin
          w_abort_inc = 1'b1;
          w_state_nxt = S_FLUSH;
        end else if (!TX_FULL) begin
          w_ready_en = 1'b1;
          if (w_g_valid) begin
            w_emit      = 1'b1;
            w_emit_byte = w_g_data;
            w_len_nxt   = r_len + 16'd1;
            if (w_g_last) w_state_nxt = S_TLH;
          end
        end
      end
      S_TLH: begin
        if (!OPEN) begin
          w_abort_inc = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (!TX_FULL) begin
          w_emit      = 1'b1;
          w_emit_byte = r_len[15:8];
          w_state_nxt = S_TLL;
        end
      end
      S_TLL: begin
        if (!OPEN) begin
          w_abort_inc = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (!TX_FULL) begin
          w_emit      = 1'b1;
          w_emit_byte = r_len[7:0];
          w_state_nxt = S_IDLE;
        end
      end
      S_FLUSH: begin
        // The rest of a cut packet is drained without emission so the source realigns.
        w_ready_en = 1'b1;
        if (w_g_valid && w_g_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state   <= S_IDLE;
      r_grant   <= 4'h0;
      r_ptr     <= 4'h0;
      r_len     <= 16'h0000;
      r_tx_wr   <= 1'b0;
      r_tx_data <= 8'h00;
      r_abort   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_len   <= w_len_nxt;
      r_tx_wr <= w_emit;
      if (w_emit) r_tx_data <= w_emit_byte;
      if (w_grant_load) begin
        r_grant <= w_sel;
        r_ptr   <= w_ptr_nxt;
      end
      if (w_abort_inc && (r_abort != '1)) r_abort <= r_abort + CNT_W'(1);
    end
  end

  assign CH_READY  = w_ready_en ? w_grant_oh : '0;
  assign TX_WR     = r_tx_wr;
  assign TX_DATA   = r_tx_data;
  assign BUSY      = (r_state != S_IDLE);
  assign GRANT_ID  = r_grant;
  assign ABORT_CNT = r_abort;

endmodule

// File: tb/tb_sitcp_tx_merger.sv
// Scoreboard bench for sitcp_tx_merger: a frame-level round-robin model queues the expected
// TX byte stream while a monitor compares every TX_WR byte against it.
module tb_sitcp_tx_merger;

  localparam int NCH  = 4;
  localparam int MEMD = 65600;

  logic             CLK, RSTn, OPEN, TX_FULL, TX_WR, BUSY;
  logic [NCH-1:0]   CH_EN, CH_VALID, CH_LAST, CH_READY;
  logic [NCH*8-1:0] CH_DATA;
  logic [7:0]       TX_DATA;
  logic [3:0]       GRANT_ID;
  logic [15:0]      ABORT_CNT;

  sitcp_tx_merger #(.NCH(NCH), .SYNC_BYTE(8'hA5), .CNT_W(16)) dut (
    .CLK(CLK), .RSTn(RSTn), .OPEN(OPEN), .CH_EN(CH_EN), .CH_VALID(CH_VALID),
    .CH_DATA(CH_DATA), .CH_LAST(CH_LAST), .CH_READY(CH_READY), .TX_FULL(TX_FULL),
    .TX_WR(TX_WR), .TX_DATA(TX_DATA), .BUSY(BUSY), .GRANT_ID(GRANT_ID), .ABORT_CNT(ABORT_CNT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Per-channel packet sources: flat byte store with last flags and read/write pointers.
  logic [7:0]     src_mem [NCH][MEMD];
  bit             src_lst [NCH][MEMD];
  int             src_n [NCH];
  int             src_rd[NCH];
  logic [NCH-1:0] hs;
  logic [NCH-1:0] watch_mask, forb;
  bit             full_rand, full_force, gap_en, full_q;
  int             cyc = 0;
  int             n_tests = 0, n_fail = 0;
  int             m_ptr;
  logic [7:0]     exp_q[$];
  int             wr_cyc_q[$];
  logic [7:0]     last_tx0, last_tx1;

  always @(posedge CLK) begin
    hs     <= CH_VALID & CH_READY;
    full_q <= TX_FULL;
    cyc    <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic put_byte(input int c, input logic [7:0] b, input bit l);
    src_mem[c][src_n[c]] = b;
    src_lst[c][src_n[c]] = l;
    src_n[c]++;
  endtask

  task automatic add_pkt(input int c, input int len);
    for (int i = 0; i < len; i++) put_byte(c, 8'($urandom_range(0, 255)), i == len - 1);
  endtask

  task automatic clear_src();
    for (int c = 0; c < NCH; c++) begin
      src_n[c]  = 0;
      src_rd[c] = 0;
    end
  endtask

  task automatic drive_src();
    logic [NCH-1:0]   v, l;
    logic [NCH*8-1:0] d;
    bit               mid;
    v = '0; l = '0; d = '0;
    for (int c = 0; c < NCH; c++) begin
      if (src_rd[c] < src_n[c]) begin
        mid  = (src_rd[c] > 0) && !src_lst[c][src_rd[c] - 1];
        v[c] = !(gap_en && mid && ($urandom_range(0, 3) == 0));
        d[8*c +: 8] = src_mem[c][src_rd[c]];
        l[c] = src_lst[c][src_rd[c]];
      end
    end
    CH_VALID = v;
    CH_DATA  = d;
    CH_LAST  = l;
  endtask

  // One cycle: observe the settled cycle, retire accepted bytes, then drive the next cycle.
  task automatic tick();
    @(negedge CLK);
    if (RSTn && OPEN && TX_FULL) check("ready_when_full", 32'(CH_READY), 32'h0);
    forb = forb | (CH_READY & watch_mask);
    for (int c = 0; c < NCH; c++) if (hs[c]) src_rd[c]++;
    TX_FULL = full_force || (full_rand && ($urandom_range(0, 3) == 0));
    drive_src();
  endtask

  // Frame-level reference: whole packets granted round-robin among enabled pending channels.
  task automatic model_run(input logic [NCH-1:0] en);
    int         rd[NCH];
    int         g, len;
    bit         found, last;
    logic [15:0] l16;
    for (int c = 0; c < NCH; c++) rd[c] = src_rd[c];
    while (1) begin
      found = 0;
      g = 0;
      for (int k = 0; k < NCH; k++) begin
        int c;
        c = (m_ptr + k) % NCH;
        if (!found && en[c] && (rd[c] < src_n[c])) begin
          found = 1;
          g = c;
        end
      end
      if (!found) break;
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'(g));
      len = 0;
      do begin
        exp_q.push_back(src_mem[g][rd[g]]);
        last = src_lst[g][rd[g]];
        rd[g]++;
        len++;
      end while (!last);
      l16 = 16'(len);
      exp_q.push_back(l16[15:8]);
      exp_q.push_back(l16[7:0]);
      m_ptr = (g + 1) % NCH;
    end
  endtask

  task automatic drain(input string name, input int budget);
    int k;
    k = 0;
    while (((exp_q.size() != 0) || BUSY) && (k < budget)) begin
      tick();
      k++;
    end
    check({name, "_left"}, exp_q.size(), 0);
    check({name, "_busy"}, 32'(BUSY), 0);
    exp_q.delete();
    repeat (3) tick();
  endtask

  task automatic wait_rd(input string name, input int c, input int target, input int budget);
    int k;
    k = 0;
    while ((src_rd[c] < target) && (k < budget)) begin
      tick();
      k++;
    end
    check({name, "_reached"}, 32'(src_rd[c] >= target), 1);
  endtask

  initial begin : monitor
    logic [7:0] e;
    forever begin
      @(negedge CLK);
      if (RSTn && full_q) check("wr_after_full", 32'(TX_WR), 32'h0);
      if (RSTn && TX_WR) begin
        wr_cyc_q.push_back(cyc);
        last_tx1 = last_tx0;
        last_tx0 = TX_DATA;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_tx: got %02h, expected no write", TX_DATA);
        end else begin
          e = exp_q.pop_front();
          check("tx_byte", 32'(TX_DATA), 32'(e));
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int c0, d;
    logic [NCH-1:0] en;
    RSTn = 1'b0; OPEN = 1'b0; TX_FULL = 1'b0;
    CH_EN = '0; CH_VALID = '0; CH_DATA = '0; CH_LAST = '0;
    full_rand = 0; full_force = 0; gap_en = 0;
    watch_mask = '0; forb = '0; m_ptr = 0;
    clear_src();

    // Reset state, with requests present to show READY stays low.
    repeat (2) @(negedge CLK);
    OPEN = 1'b1; CH_EN = '1; CH_VALID = '1;
    @(negedge CLK);
    check("rst_tx_wr", 32'(TX_WR), 0);
    check("rst_tx_data", 32'(TX_DATA), 0);
    check("rst_busy", 32'(BUSY), 0);
    check("rst_grant", 32'(GRANT_ID), 0);
    check("rst_abort", 32'(ABORT_CNT), 0);
    check("rst_ready", 32'(CH_READY), 0);
    drive_src();
    RSTn = 1'b1;
    repeat (2) tick();

    // ch0 and ch2 each hold two 2-byte packets: frames alternate starting at ch0.
    watch_mask = 4'b1010; forb = '0;
    add_pkt(0, 2); add_pkt(0, 2); add_pkt(2, 2); add_pkt(2, 2);
    model_run(CH_EN);
    drive_src();
    drain("rr02", 200);
    check("rr02_idle_ready", 32'(forb), 0);
    watch_mask = '0;

    // ch1 three-byte frame, fixed expectation, latency and back-to-back output.
    clear_src();
    put_byte(1, 8'h11, 0); put_byte(1, 8'h22, 0); put_byte(1, 8'h33, 1);
    foreach (exp_q[i]) exp_q.delete(i);
    exp_q = {8'hA5, 8'h01, 8'h11, 8'h22, 8'h33, 8'h00, 8'h03};
    m_ptr = 2;
    wr_cyc_q.delete();
    drive_src();
    c0 = cyc;
    drain("ch1", 100);
    check("ch1_wr_count", wr_cyc_q.size(), 7);
    if (wr_cyc_q.size() == 7) begin
      check("ch1_latency", wr_cyc_q[0] - c0, 2);
      check("ch1_back2back", wr_cyc_q[6] - wr_cyc_q[0], 6);
    end

    // TX_FULL held for 5 cycles mid-payload.
    clear_src();
    add_pkt(2, 8);
    model_run(CH_EN);
    drive_src();
    wait_rd("full", 2, 3, 100);
    full_force = 1;
    repeat (5) tick();
    full_force = 0;
    drain("full", 100);

    // Randomised traffic with back-pressure, valid gaps and one disabled channel.
    clear_src();
    d = $urandom_range(0, NCH - 1);
    en = ~(NCH'(1) << d);
    CH_EN = en;
    watch_mask = NCH'(1) << d; forb = '0;
    for (int c = 0; c < NCH; c++) begin
      int np;
      np = $urandom_range(2, 5);
      for (int p = 0; p < np; p++) add_pkt(c, $urandom_range(1, 10));
    end
    model_run(en);
    gap_en = 1; full_rand = 1;
    drive_src();
    drain("rand", 6000);
    check("rand_disabled_untouched", src_rd[d], 0);
    check("rand_disabled_ready", 32'(forb), 0);
    gap_en = 0; full_rand = 0; watch_mask = '0;
    clear_src(); drive_src();
    CH_EN = '1;
    repeat (2) tick();

    // Connection drop after two payload bytes of a six-byte packet.
    clear_src();
    add_pkt(0, 6);
    exp_q = {8'hA5, 8'h00, src_mem[0][0], src_mem[0][1]};
    m_ptr = 1;
    drive_src();
    wait_rd("abort", 0, 2, 100);
    OPEN = 1'b0;
    wait_rd("flush", 0, 6, 100);
    tick();
    check("abort_busy", 32'(BUSY), 0);
    check("abort_cnt", 32'(ABORT_CNT), 1);
    check("abort_left", exp_q.size(), 0);
    OPEN = 1'b1;
    drain("abort", 20);

    // 65537-byte packet: length field wraps to 1.
    clear_src();
    add_pkt(3, 65537);
    model_run(CH_EN);
    drive_src();
    drain("big", 70000);
    check("big_trailer_hi", 32'(last_tx1), 32'h00);
    check("big_trailer_lo", 32'(last_tx0), 32'h01);

    // Reset asserted mid-payload, then ch0 must win over ch2.
    clear_src();
    add_pkt(1, 10);
    model_run(CH_EN);
    drive_src();
    wait_rd("rstpay", 1, 3, 100);
    RSTn = 1'b0;
    clear_src(); drive_src();
    #1;
    check("midrst_tx_wr", 32'(TX_WR), 0);
    check("midrst_busy", 32'(BUSY), 0);
    check("midrst_grant", 32'(GRANT_ID), 0);
    check("midrst_abort", 32'(ABORT_CNT), 0);
    exp_q.delete();
    repeat (2) tick();
    RSTn = 1'b1;
    m_ptr = 0;
    add_pkt(2, 3); add_pkt(0, 3);
    model_run(CH_EN);
    drive_src();
    drain("postrst", 100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
